// File: rtl/conc_stim_player.sv
// conc_stim_player: replays a programmed list of {hold, obs, data} entries
// into a DUT, one entry per step, with per-entry hold counts, one-shot or
// looping playback and a start/stop/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | not playing; outputs keep last value (or zero after stop)
// ST_RUN  | playing entry r_pc, r_hold cycles left on current entry
module conc_stim_player #(
  parameter  int DATA_W = 2,
  parameter  int DEPTH  = 16,
  parameter  int HOLD_W = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int W      = HOLD_W + 1 + DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] stim_out,
  output logic              obs_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [DATA_W-1:0] r_stim, w_stim_nxt;
  logic              r_obs, w_obs_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [31:0]       r_cyc, w_cyc_nxt;

  logic [ADDR_W:0]   w_len_cap;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [W-1:0]      w_ent0;
  logic [W-1:0]      w_ent_nx;
  logic              w_last;

  assign w_len_cap = (length > LP_DEPTH) ? LP_DEPTH : length;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_ent0    = r_mem[0];
  assign w_ent_nx  = r_mem[w_pc_inc];
  assign w_last    = ({1'b0, r_pc} == (r_len - (ADDR_W+1)'(1)));

  // Program memory: plain write port, out-of-range addresses dropped, no reset.
  always_ff @(posedge clock) begin
    if (wr_en && ({1'b0, wr_addr} < LP_DEPTH)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_hold  <= '0;
      r_stim  <= '0;
      r_obs   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      r_hold  <= w_hold_nxt;
      r_stim  <= w_stim_nxt;
      r_obs   <= w_obs_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  // Next-state and next-output logic; stop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_hold_nxt  = r_hold;
    w_stim_nxt  = r_stim;
    w_obs_nxt   = r_obs;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cyc_nxt   = r_cyc;

    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_stim_nxt  = '0;
      w_obs_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_len_cap != '0) begin
              w_state_nxt = ST_RUN;
              w_len_nxt   = w_len_cap;
              w_pc_nxt    = '0;
              w_stim_nxt  = w_ent0[DATA_W-1:0];
              w_obs_nxt   = w_ent0[DATA_W];
              w_hold_nxt  = w_ent0[W-1:DATA_W+1];
              w_busy_nxt  = 1'b1;
              w_cyc_nxt   = '0;
            end else begin
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          w_cyc_nxt = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;
          if (r_hold != '0) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
          end else if (!w_last) begin
            w_pc_nxt   = w_pc_inc;
            w_stim_nxt = w_ent_nx[DATA_W-1:0];
            w_obs_nxt  = w_ent_nx[DATA_W];
            w_hold_nxt = w_ent_nx[W-1:DATA_W+1];
          end else if (loop_en) begin
            w_pc_nxt   = '0;
            w_stim_nxt = w_ent0[DATA_W-1:0];
            w_obs_nxt  = w_ent0[DATA_W];
            w_hold_nxt = w_ent0[W-1:DATA_W+1];
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign stim_out  = r_stim;
  assign obs_out   = r_obs;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pc_out    = r_pc;
  assign cycle_cnt = r_cyc;

endmodule

// File: tb/tb_conc_stim_player.sv
// Directed bench for conc_stim_player (DATA_W=2, DEPTH=16, HOLD_W=4).
module tb_conc_stim_player;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [4:0]  length;
  logic [1:0]  stim_out;
  logic        obs_out;
  logic        busy;
  logic        done;
  logic [3:0]  pc_out;
  logic [31:0] cycle_cnt;

  int n_vec = 0;
  int n_err = 0;

  conc_stim_player #(.DATA_W(2), .DEPTH(16), .HOLD_W(4)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .length    (length),
    .stim_out  (stim_out),
    .obs_out   (obs_out),
    .busy      (busy),
    .done      (done),
    .pc_out    (pc_out),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic prog(input int addr, input int hold, input bit obs, input int data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = {4'(hold), obs, 2'(data)};
    step();
    wr_en   = 1'b0;
  endtask

  task automatic kick(input int len, input bit lp);
    length  = 5'(len);
    loop_en = lp;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int stim, input bit obs, input bit bsy);
    chk({tag, "_stim"}, 32'(stim_out), 32'(stim));
    chk({tag, "_obs"},  32'(obs_out),  32'(obs));
    chk({tag, "_busy"}, 32'(busy),     32'(bsy));
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0;
    step(); step();
    chk_out("rst", 0, 1'b0, 1'b0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_cyc", cycle_cnt, 0);
    reset_n = 1'b1;
    step();

    // One-shot, three entries, no hold.
    prog(0, 0, 1'b1, 1);
    prog(1, 0, 1'b0, 2);
    prog(2, 0, 1'b1, 3);
    kick(3, 1'b0);
    chk_out("t1_e0", 1, 1'b1, 1'b1);
    chk("t1_pc0", 32'(pc_out), 0);
    step(); chk_out("t1_e1", 2, 1'b0, 1'b1);
    step(); chk_out("t1_e2", 3, 1'b1, 1'b1);
    chk("t1_pc2", 32'(pc_out), 2);
    step(); chk_out("t1_end", 3, 1'b1, 1'b0);
    chk("t1_done", 32'(done), 1);
    chk("t1_cyc", cycle_cnt, 3);
    chk("t1_pc_keep", 32'(pc_out), 2);
    step(); chk("t1_done_fall", 32'(done), 0);
    chk("t1_cyc_hold", cycle_cnt, 3);

    // Hold count: entry0 held 4 cycles, entry1 1 cycle.
    prog(0, 3, 1'b0, 2);
    prog(1, 0, 1'b1, 1);
    kick(2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_out("t2_hold", 2, 1'b0, 1'b1);
      step();
    end
    chk_out("t2_e1", 1, 1'b1, 1'b1);
    chk("t2_pc1", 32'(pc_out), 1);
    step();
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_cyc", cycle_cnt, 5);

    // Loop mode A,B,A,B,A,B then drop loop_en while B is driven.
    prog(0, 0, 1'b0, 1);
    prog(1, 0, 1'b1, 2);
    kick(2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) chk_out("t3_a", 1, 1'b0, 1'b1);
      else            chk_out("t3_b", 2, 1'b1, 1'b1);
      chk("t3_nodone", 32'(done), 0);
      if (k == 5) loop_en = 1'b0;
      step();
    end
    chk_out("t3_end", 2, 1'b1, 1'b0);
    chk("t3_done", 32'(done), 1);
    chk("t3_cyc", cycle_cnt, 6);

    // Stop mid-hold together with start.
    prog(0, 5, 1'b1, 3);
    prog(1, 0, 1'b1, 1);
    kick(2, 1'b0);
    chk_out("t4_run", 3, 1'b1, 1'b1);
    step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk_out("t4_stop", 0, 1'b0, 1'b0);
    chk("t4_nodone", 32'(done), 0);
    step();
    chk("t4_nodone2", 32'(done), 0);
    chk("t4_idle", 32'(busy), 0);
    kick(2, 1'b0);
    chk_out("t4_restart", 3, 1'b1, 1'b1);
    chk("t4_pc", 32'(pc_out), 0);
    chk("t4_cyc0", cycle_cnt, 0);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        if (done) got = 1'b1;
      end
      chk("t4_done_seen", 32'(got), 1);
      chk("t4_cyc", cycle_cnt, 7);
      chk("t4_last", 32'(stim_out), 1);
    end

    // length 0: no busy, one done pulse, outputs untouched.
    step();
    kick(0, 1'b0);
    chk_out("t5_len0", 1, 1'b1, 1'b0);
    chk("t5_done", 32'(done), 1);
    step();
    chk("t5_done_fall", 32'(done), 0);
    chk("t5_busy", 32'(busy), 0);

    // length beyond DEPTH clamps to 16 entries.
    for (int i = 0; i < 16; i++) prog(i, 0, i[0], i & 3);
    kick(20, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_out("t6_ent", i & 3, i[0], 1'b1);
      chk("t6_pc", 32'(pc_out), 32'(i));
      step();
    end
    chk("t6_done", 32'(done), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cyc", cycle_cnt, 16);
    step();

    // Asynchronous reset during RUN, then identical replay.
    kick(3, 1'b0);
    step();
    chk_out("t7_pre", 1, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_out("t7_rst", 0, 1'b0, 1'b0);
    chk("t7_pc", 32'(pc_out), 0);
    chk("t7_cyc", cycle_cnt, 0);
    step();
    reset_n = 1'b1;
    step();
    kick(3, 1'b0);
    chk_out("t7_r0", 0, 1'b0, 1'b1);
    step(); chk_out("t7_r1", 1, 1'b1, 1'b1);
    step(); chk_out("t7_r2", 2, 1'b0, 1'b1);
    step();
    chk("t7_done", 32'(done), 1);
    chk("t7_cyc3", cycle_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
